fetch_decode: RTL and testbench
===============================

# fetch_decode

Front-end stage of the Harvard Architecture Processor: fetches 16-bit instruction words from the separate instruction memory, decodes opcode and register fields, reads an internal 8-entry register file, and presents `opcode`/`R1`/`R2` to the execute stage (compare/ALU) under a valid/ready handshake. It also absorbs result write-back and branch redirects coming back from execute.

## Interface
- `PC_W`, 8, program counter / instruction address width
- `DATA_W`, 3, register and operand width (matches execute-stage operands)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_addr`  out  PC_W  instruction memory address (= `pc`)
- `imem_data`  in  16  instruction word; valid the cycle after `imem_addr` is driven (synchronous ROM)
- `ex_valid`  out  1  decoded instruction offered to execute
- `ex_ready`  in  1  execute accepts the offer
- `opcode`  out  5  decoded opcode
- `R1`, `R2`  out  DATA_W  operand values for rs1, rs2
- `rd_addr`  out  3  destination register
- `wb_en`  in  1  write-back strobe
- `wb_addr`  in  3  write-back register
- `wb_data`  in  DATA_W  write-back value
- `br_taken`  in  1  redirect request
- `br_target`  in  PC_W  redirect address
- `halted`  out  1  HALT executed

## Operation
- Instruction format: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] ignored.
- Register file: 8 x DATA_W; r0 reads 0, writes to r0 ignored. Write on `wb_en` at clock edge in every state including HALT.
- FSM states: FETCH, DECODE, ISSUE, HALT.
  - FETCH: `imem_addr`=pc; -> DECODE.
  - DECODE: capture `imem_data`; read rs1/rs2; pc <= pc+1 (mod 2^PC_W, 0xFF wraps to 0x00). NOP (5'b00000) -> FETCH, not issued. HALT (5'b11111) -> HALT, not issued. Otherwise load output registers -> ISSUE.
  - ISSUE: `ex_valid`=1; outputs held stable until `ex_valid && ex_ready`; then -> FETCH.
  - HALT: `halted`=1, `ex_valid`=0; exits only via reset. `br_taken` ignored.
- Write-back bypass: in DECODE, if `wb_en` and `wb_addr`==rs1 (resp. rs2) and address != 0, operand takes `wb_data`.
- Redirect: `br_taken` in FETCH/DECODE/ISSUE sets pc <= `br_target` and next state FETCH. In-flight instruction not yet accepted is squashed (`ex_valid` drops next cycle). If `ex_valid && ex_ready && br_taken` coincide, the transfer completes and the redirect still applies. Redirect in DECODE has priority over pc+1 and over NOP/HALT decode.
- Opcodes are not range-checked; unknown opcodes are issued unchanged (execute defaults them).

## Timing
- Reset (async, immediate): pc=0, state FETCH, `ex_valid`=0, `opcode`=0, `R1`=`R2`=0, `rd_addr`=0, `halted`=0, register file cleared.
- First fetch address 0 in first cycle after `rst_n` rises.
- Latency: `imem_addr` driven cycle N, `ex_valid` high cycle N+2. Throughput with `ex_ready`=1: one instruction per 3 cycles.
- Back-pressure: each cycle of `ex_ready`=0 in ISSUE adds one cycle; no output changes while waiting.
- Write-back at cycle N visible to DECODE in cycle N via bypass, to later reads via register file.
- Reset asserted mid-ISSUE: `ex_valid` falls asynchronously; no handshake completes.

## Structure
- Shared package `hap_pkg`: opcode constants (NOP 00000, LT 01011, GT 01100, EQ 01101, GTE 01110, LTE 01111, NE 10000, HALT 11111), instruction field positions, state encoding.
- One sub-module: `hap_regfile` (8 x DATA_W, two combinational read ports, one write port, r0 = 0, async reset clear).

## Test plan
- Reset, ROM[0]=EQ rd=1 rs1=0 rs2=0, `ex_ready`=1 -> `imem_addr`=0 cycle 1, `ex_valid` cycle 3 with opcode 01101, R1=R2=0, rd_addr=1.
- `wb_en` r2=5, r3=3, then LT rs1=2 rs2=3 -> R1=5, R2=3; also wb r2=6 in the DECODE cycle -> R1=6 (bypass).
- `ex_ready`=0 for 4 cycles in ISSUE -> `ex_valid` and outputs held constant 4 cycles, accepted on 5th.
- `br_taken`=1, target 0x40 in ISSUE with `ex_ready`=0 -> instruction squashed, next `imem_addr`=0x40; repeat with `ex_ready`=1 -> one transfer, then fetch 0x40.
- pc at 0xFF with NOP -> next fetch 0x00, nothing issued; HALT at 0x05 -> `halted`=1, `ex_valid` stays 0, `br_taken` ignored until reset.
- Assert `rst_n`=0 mid-ISSUE -> all outputs at reset values immediately; register file reads 0 after release.

Source files
------------

// File: rtl/hap_pkg.sv
// Shared definitions for the Harvard Architecture Processor front end:
// opcode constants, instruction field positions and FSM state encoding.
package hap_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LT   = 5'b01011;
    localparam logic [4:0] OP_GT   = 5'b01100;
    localparam logic [4:0] OP_EQ   = 5'b01101;
    localparam logic [4:0] OP_GTE  = 5'b01110;
    localparam logic [4:0] OP_LTE  = 5'b01111;
    localparam logic [4:0] OP_NE   = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 2;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/hap_regfile.sv
// 8-entry register file: two combinational read ports, one write port.
// r0 always reads zero and ignores writes; contents clear on reset.
module hap_regfile
    import hap_pkg::*;
#(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr1,
    input  logic [2:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_mem [0:7];

    // Register storage with asynchronous clear; r0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != 3'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end else begin
            r_mem <= r_mem;
        end
    end

    assign o_rdata1 = (i_raddr1 == 3'd0) ? {DATA_W{1'b0}} : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 3'd0) ? {DATA_W{1'b0}} : r_mem[i_raddr2];

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: fetches from synchronous instruction ROM, decodes,
// reads operands (with write-back bypass) and offers them to execute.
module fetch_decode
    import hap_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [4:0]        opcode,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [2:0]        rd_addr,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic              halted
);

    state_t            r_state;
    state_t            w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic              w_load;
    logic              r_ex_valid;
    logic              r_halted;
    logic [4:0]        r_opcode;
    logic [DATA_W-1:0] r_r1;
    logic [DATA_W-1:0] r_r2;
    logic [2:0]        r_rd;

    logic [4:0]        w_opc;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic [DATA_W-1:0] w_rf1;
    logic [DATA_W-1:0] w_rf2;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic              w_unused;

    assign w_opc    = imem_data[OPC_MSB:OPC_LSB];
    assign w_rd     = imem_data[RD_MSB:RD_LSB];
    assign w_rs1    = imem_data[RS1_MSB:RS1_LSB];
    assign w_rs2    = imem_data[RS2_MSB:RS2_LSB];
    assign w_unused = ^imem_data[1:0];

    hap_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (wb_en),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rf1),
        .o_rdata2 (w_rf2)
    );

    // A same-cycle write-back overrides the stale register file value.
    assign w_op1 = (wb_en && (wb_addr == w_rs1) && (w_rs1 != 3'd0)) ? wb_data : w_rf1;
    assign w_op2 = (wb_en && (wb_addr == w_rs2) && (w_rs2 != 3'd0)) ? wb_data : w_rf2;

    // State and program counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Next-state, next-pc and issue-load decisions; redirects win over everything but HALT.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (br_taken) begin
                    w_pc_next = br_target;
                end else begin
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (br_taken) begin
                    w_pc_next    = br_target;
                    w_state_next = ST_FETCH;
                end else begin
                    w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                    if (w_opc == OP_NOP) begin
                        w_state_next = ST_FETCH;
                    end else if (w_opc == OP_HALT) begin
                        w_state_next = ST_HALT;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (br_taken) begin
                    w_pc_next    = br_target;
                    w_state_next = ST_FETCH;
                end else if (ex_ready) begin
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // Registered execute-side outputs, loaded only when an instruction is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_halted   <= 1'b0;
            r_opcode   <= 5'd0;
            r_r1       <= '0;
            r_r2       <= '0;
            r_rd       <= 3'd0;
        end else begin
            r_ex_valid <= (w_state_next == ST_ISSUE);
            r_halted   <= (w_state_next == ST_HALT);
            if (w_load) begin
                r_opcode <= w_opc;
                r_r1     <= w_op1;
                r_r2     <= w_op2;
                r_rd     <= w_rd;
            end else begin
                r_opcode <= r_opcode;
                r_r1     <= r_r1;
                r_r2     <= r_r2;
                r_rd     <= r_rd;
            end
        end
    end

    assign imem_addr = r_pc;
    assign ex_valid  = r_ex_valid;
    assign halted    = r_halted;
    assign opcode    = r_opcode;
    assign R1        = r_r1;
    assign R2        = r_r2;
    assign rd_addr   = r_rd;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode with a synchronous ROM model.
module tb_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  opcode;
    logic [2:0]  R1;
    logic [2:0]  R2;
    logic [2:0]  rd_addr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [2:0]  wb_data;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        halted;

    logic [15:0] rom [0:255];
    int          n_checks;
    int          n_fail;
    int          xfers;
    int          xfers_snap;

    fetch_decode #(.PC_W(8), .DATA_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .opcode    (opcode),
        .R1        (R1),
        .R2        (R2),
        .rd_addr   (rd_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .br_taken  (br_taken),
        .br_target (br_target),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    always @(posedge clk) begin
        if (ex_valid && ex_ready) xfers <= xfers + 1;
    end

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},  {31'd0, ex_valid}, 32'd0);
        chk({tag, "_opcode"}, {27'd0, opcode},   32'd0);
        chk({tag, "_r1"},     {29'd0, R1},       32'd0);
        chk({tag, "_r2"},     {29'd0, R2},       32'd0);
        chk({tag, "_rd"},     {29'd0, rd_addr},  32'd0);
        chk({tag, "_halted"}, {31'd0, halted},   32'd0);
        chk({tag, "_addr"},   {24'd0, imem_addr}, 32'd0);
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; imem_data = 16'd0;
        ex_ready = 1'b1; wb_en = 1'b0; wb_addr = 3'd0; wb_data = 3'd0;
        br_taken = 1'b0; br_target = 8'd0;
        n_checks = 0; n_fail = 0; xfers = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = enc(5'b01101, 3'd1, 3'd0, 3'd0);
        rom[8'h01] = enc(5'b01011, 3'd4, 3'd2, 3'd3);
        rom[8'h02] = enc(5'b01011, 3'd5, 3'd2, 3'd3);
        rom[8'h03] = enc(5'b01100, 3'd6, 3'd3, 3'd2);
        rom[8'h05] = enc(5'b11111, 3'd0, 3'd0, 3'd0);
        rom[8'h40] = enc(5'b10000, 3'd7, 3'd1, 3'd1);

        tick(); tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // cycle 1: FETCH 0, write r2=5
        chk("c1_addr", {24'd0, imem_addr}, 32'h0);
        chk("c1_valid", {31'd0, ex_valid}, 32'd0);
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 3'd5;
        tick();
        // cycle 2: DECODE EQ, write r3=3
        chk("c2_valid", {31'd0, ex_valid}, 32'd0);
        wb_addr = 3'd3; wb_data = 3'd3;
        tick();
        wb_en = 1'b0;
        // cycle 3: ISSUE EQ
        chk("eq_valid", {31'd0, ex_valid}, 32'd1);
        chk("eq_opcode", {27'd0, opcode}, 32'h0D);
        chk("eq_r1", {29'd0, R1}, 32'd0);
        chk("eq_r2", {29'd0, R2}, 32'd0);
        chk("eq_rd", {29'd0, rd_addr}, 32'd1);
        tick();
        chk("c4_valid", {31'd0, ex_valid}, 32'd0);
        chk("c4_addr", {24'd0, imem_addr}, 32'h1);
        tick(); tick();
        // LT from register file
        chk("lt_valid", {31'd0, ex_valid}, 32'd1);
        chk("lt_opcode", {27'd0, opcode}, 32'h0B);
        chk("lt_r1", {29'd0, R1}, 32'd5);
        chk("lt_r2", {29'd0, R2}, 32'd3);
        chk("lt_rd", {29'd0, rd_addr}, 32'd4);
        chk("xfer_two", xfers, 32'd1);
        tick();
        chk("c7_addr", {24'd0, imem_addr}, 32'h2);
        tick();
        // DECODE of LT #2 with same-cycle write r2=6
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 3'd6; ex_ready = 1'b0;
        tick();
        wb_en = 1'b0;
        chk("byp_r1", {29'd0, R1}, 32'd6);
        chk("byp_r2", {29'd0, R2}, 32'd3);
        chk("byp_rd", {29'd0, rd_addr}, 32'd5);
        xfers_snap = xfers;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {31'd0, ex_valid}, 32'd1);
            chk("bp_r1", {29'd0, R1}, 32'd6);
            chk("bp_rd", {29'd0, rd_addr}, 32'd5);
            chk("bp_addr", {24'd0, imem_addr}, 32'h3);
            tick();
        end
        ex_ready = 1'b1;
        chk("bp5_valid", {31'd0, ex_valid}, 32'd1);
        chk("bp5_opcode", {27'd0, opcode}, 32'h0B);
        tick();
        chk("bp_accept_valid", {31'd0, ex_valid}, 32'd0);
        chk("bp_accept_xfer", xfers, xfers_snap + 1);
        chk("bp_next_addr", {24'd0, imem_addr}, 32'h3);
        tick(); tick();
        // ISSUE GT: redirect while not ready -> squash
        chk("gt_valid", {31'd0, ex_valid}, 32'd1);
        ex_ready = 1'b0; br_taken = 1'b1; br_target = 8'h40;
        xfers_snap = xfers;
        tick();
        br_taken = 1'b0; ex_ready = 1'b1;
        chk("sq_valid", {31'd0, ex_valid}, 32'd0);
        chk("sq_addr", {24'd0, imem_addr}, 32'h40);
        chk("sq_xfer", xfers, xfers_snap);
        tick(); tick();
        // ISSUE NE with ready and redirect together
        chk("ne_valid", {31'd0, ex_valid}, 32'd1);
        chk("ne_opcode", {27'd0, opcode}, 32'h10);
        chk("ne_rd", {29'd0, rd_addr}, 32'd7);
        br_taken = 1'b1; br_target = 8'hFF;
        tick();
        br_taken = 1'b0;
        chk("co_xfer", xfers, xfers_snap + 1);
        chk("co_valid", {31'd0, ex_valid}, 32'd0);
        chk("co_addr", {24'd0, imem_addr}, 32'hFF);
        tick();
        chk("nop_dec_valid", {31'd0, ex_valid}, 32'd0);
        tick();
        chk("wrap_addr", {24'd0, imem_addr}, 32'h00);
        chk("nop_valid", {31'd0, ex_valid}, 32'd0);
        br_taken = 1'b1; br_target = 8'h05;
        tick();
        br_taken = 1'b0;
        chk("fr_addr", {24'd0, imem_addr}, 32'h05);
        tick(); tick();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, ex_valid}, 32'd0);
        chk("halt_addr", {24'd0, imem_addr}, 32'h06);
        br_taken = 1'b1; br_target = 8'h40;
        tick(); tick();
        br_taken = 1'b0;
        tick();
        chk("halt_br_halted", {31'd0, halted}, 32'd1);
        chk("halt_br_valid", {31'd0, ex_valid}, 32'd0);
        chk("halt_br_addr", {24'd0, imem_addr}, 32'h06);
        chk("halt_xfer", xfers, xfers_snap + 1);

        // reset out of HALT, then reset again mid-ISSUE
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ex_ready = 1'b0;
        tick(); tick();
        chk("mi_valid", {31'd0, ex_valid}, 32'd1);
        xfers_snap = xfers;
        #2;
        rst_n = 1'b0; ex_ready = 1'b1;
        #1;
        chk_reset_outputs("mid");
        tick();
        chk("mid_xfer", xfers, xfers_snap);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        chk("post_opcode", {27'd0, opcode}, 32'h0B);
        chk("post_r1", {29'd0, R1}, 32'd0);
        chk("post_r2", {29'd0, R2}, 32'd0);
        chk("post_rd", {29'd0, rd_addr}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
